// File: rtl/zigzag_scan_buffer.sv
// Ping-pong coefficient buffer: raster-order writes, zigzag (forward or reverse) reads.
// Supports 4x4 blocks and 2x2 chroma DC blocks, one coefficient per cycle each side.
module zigzag_scan_buffer #(
  parameter int COEF_WIDTH = 16,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [COEF_WIDTH-1:0] in_data,
  input  logic                  blk_mode,
  input  logic                  scan_rev,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COEF_WIDTH-1:0] out_data,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic                  out_first,
  output logic                  out_last
);

  logic       wr_bank_reg, rd_bank_reg;
  logic [3:0] wr_cnt_reg, rd_cnt_reg;
  logic [1:0] full_vec, mode_vec, rev_vec;
  logic [COEF_WIDTH-1:0] bank_word [2];

  logic       wr_fire, wr_mode, wr_last;
  logic       rd_fire, rd_mode, rd_rev, rd_last;
  logic [3:0] rd_idx;

  // Forward 4x4 zigzag: scan position -> raster position.
  function automatic logic [3:0] zz4(input logic [3:0] k);
    logic [3:0] r;
    case (k)
      4'd0:  r = 4'd0;
      4'd1:  r = 4'd1;
      4'd2:  r = 4'd4;
      4'd3:  r = 4'd8;
      4'd4:  r = 4'd5;
      4'd5:  r = 4'd2;
      4'd6:  r = 4'd3;
      4'd7:  r = 4'd6;
      4'd8:  r = 4'd9;
      4'd9:  r = 4'd12;
      4'd10: r = 4'd13;
      4'd11: r = 4'd10;
      4'd12: r = 4'd7;
      4'd13: r = 4'd11;
      4'd14: r = 4'd14;
      default: r = 4'd15;
    endcase
    return r;
  endfunction

  // A block's mode only becomes authoritative once its first coefficient lands.
  assign wr_mode  = (wr_cnt_reg == 4'd0) ? blk_mode : mode_vec[wr_bank_reg];
  assign wr_last  = (wr_cnt_reg == (wr_mode ? 4'd3 : 4'd15));
  assign in_ready = ~full_vec[wr_bank_reg];
  assign wr_fire  = in_valid & in_ready;

  assign rd_mode   = mode_vec[rd_bank_reg];
  assign rd_rev    = rev_vec[rd_bank_reg];
  assign rd_last   = (rd_cnt_reg == (rd_mode ? 4'd3 : 4'd15));
  assign out_valid = full_vec[rd_bank_reg];
  assign rd_fire   = out_valid & out_ready;

  always_comb begin
    rd_idx = 4'd0;
    if (rd_mode)
      rd_idx = rd_rev ? (4'd3 - rd_cnt_reg) : rd_cnt_reg;
    else
      rd_idx = rd_rev ? zz4(4'd15 - rd_cnt_reg) : zz4(rd_cnt_reg);
  end

  assign out_data  = bank_word[rd_bank_reg];
  assign out_idx   = IDX_WIDTH'(rd_cnt_reg);
  assign out_first = out_valid & (rd_cnt_reg == 4'd0);
  assign out_last  = out_valid & rd_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      wr_cnt_reg  <= 4'd0;
      rd_cnt_reg  <= 4'd0;
    end else if (flush) begin
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      wr_cnt_reg  <= 4'd0;
      rd_cnt_reg  <= 4'd0;
    end else begin
      if (wr_fire) begin
        if (wr_last) begin
          wr_cnt_reg  <= 4'd0;
          wr_bank_reg <= ~wr_bank_reg;
        end else begin
          wr_cnt_reg <= wr_cnt_reg + 4'd1;
        end
      end
      if (rd_fire) begin
        if (rd_last) begin
          rd_cnt_reg  <= 4'd0;
          rd_bank_reg <= ~rd_bank_reg;
        end else begin
          rd_cnt_reg <= rd_cnt_reg + 4'd1;
        end
      end
    end
  end

  // Per-bank storage; a bank is only written while not full and only drained while full.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    localparam logic BANK = 1'(gi);
    logic                  full_reg, mode_reg, rev_reg;
    logic [COEF_WIDTH-1:0] mem_reg [16];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        full_reg <= 1'b0;
        mode_reg <= 1'b0;
        rev_reg  <= 1'b0;
        for (int j = 0; j < 16; j++) mem_reg[j] <= '0;
      end else if (flush) begin
        full_reg <= 1'b0;
        mode_reg <= 1'b0;
        rev_reg  <= 1'b0;
        for (int j = 0; j < 16; j++) mem_reg[j] <= '0;
      end else begin
        if (wr_fire && (wr_bank_reg == BANK)) begin
          mem_reg[wr_cnt_reg] <= in_data;
          if (wr_cnt_reg == 4'd0) begin
            mode_reg <= blk_mode;
            rev_reg  <= scan_rev;
          end
          if (wr_last) full_reg <= 1'b1;
        end
        if (rd_fire && rd_last && (rd_bank_reg == BANK)) full_reg <= 1'b0;
      end
    end

    assign full_vec[gi]  = full_reg;
    assign mode_vec[gi]  = mode_reg;
    assign rev_vec[gi]   = rev_reg;
    assign bank_word[gi] = mem_reg[rd_idx];
  end

endmodule

// File: doc/zigzag_scan_buffer.md
Name: zigzag_scan_buffer

Overview:
Ping-pong coefficient buffer that accepts quantised residual coefficients in raster order and re-emits each block in zigzag scan order, either forward or reverse. Reverse order feeds the CAVLC level/run encoder directly. Parametrised successor to the fixed 4x4 zigzag order table. Adds selectable 4x4 and 2x2 (chroma DC) block sizes, per-block direction, valid/ready handshakes on both sides, and double buffering. Sits between the quantiser output and the CAVLC coefficient-statistics stage.

Parameters:
COEF_WIDTH, 16, signed coefficient width in bits
IDX_WIDTH, 4, width of the scan-position index output (fixed at 4 for 16-entry blocks)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of both banks and all counters
in_valid  input  1  input coefficient valid
in_ready  output  1  buffer can accept a coefficient
in_data  input  COEF_WIDTH  coefficient, raster order
blk_mode  input  1  0 = 4x4 (16 coefs), 1 = 2x2 chroma DC (4 coefs); sampled on first write of a block
scan_rev  input  1  0 = forward zigzag, 1 = reverse; sampled on first write of a block
out_valid  output  1  output coefficient valid
out_ready  input  1  downstream accepts
out_data  output  COEF_WIDTH  coefficient in scan order
out_idx  output  IDX_WIDTH  scan position of out_data (0 = first emitted)
out_first  output  1  first coefficient of block
out_last  output  1  last coefficient of block

Behaviour:
- Storage: two banks × 16 × COEF_WIDTH registers. Per bank: full flag, latched blk_mode, latched scan_rev.
- Write side: wr_bank, wr_cnt.
  - in_ready = ~full[wr_bank].
  - Transfer when in_valid & in_ready: mem[wr_bank][wr_cnt] <= in_data, wr_cnt++.
  - On wr_cnt==0 transfer: latch blk_mode and scan_rev into the bank.
  - Block length N = 16 (4x4) or 4 (2x2). On the transfer with wr_cnt==N-1: full[wr_bank] <= 1, wr_cnt <= 0, wr_bank toggles.
- Read side: rd_bank, rd_cnt.
  - out_valid = full[rd_bank].
  - out_data = mem[rd_bank][map(rd_cnt)], a combinational mux of registers.
  - out_idx = rd_cnt. out_first = (rd_cnt==0) & out_valid. out_last = (rd_cnt==N-1) & out_valid.
  - Transfer when out_valid & out_ready: rd_cnt++. On the last transfer: full[rd_bank] <= 0, rd_cnt <= 0, rd_bank toggles.
- Scan map, 4x4 forward, k -> raster: 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
- Reverse map: k -> forward[15-k], i.e. 15,14,11,7,10,13,12,9,6,3,2,5,8,4,1,0.
- 2x2 map: forward 0,1,2,3; reverse 3,2,1,0.
- Latency: the first output of a block is valid the cycle after its final input is accepted.
- Throughput: 1 coefficient/cycle sustained. The write of bank A and the drain of bank B proceed in the same cycle.
- Full/back-pressure:
  - Both banks full -> in_ready = 0.
  - out_ready low -> out_data, out_idx, out_first, out_last held stable while out_valid = 1.
- Simultaneous events on the same bank: setting full (write) and clearing full (read) cannot target one bank in one cycle, because a bank is only read when full and only written when not full.
- Mode change mid-block: blk_mode and scan_rev are ignored until the next block's first write.
- flush: takes priority over any transfer that cycle. Next cycle: all full flags = 0, wr/rd bank = 0, wr/rd cnt = 0. A partial block is discarded.
- Reset values (asynchronous, and after flush): in_ready = 1, out_valid = 0, out_first = 0, out_last = 0, out_idx = 0. out_data is a mux of reset-zeroed storage, so it reads 0.
- Reset asserted mid-operation: all state is cleared immediately. Any in-flight blocks are lost.

Test Plan:
- Forward 4x4: send raster values 0..15, scan_rev=0, out_ready=1 -> out_data 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15. out_first on idx 0, out_last on idx 15. First out_valid 1 cycle after the 16th input.
- Reverse 4x4: same input, scan_rev=1 -> out_data 15,14,11,7,10,13,12,9,6,3,2,5,8,4,1,0.
- 2x2 DC: blk_mode=1, scan_rev=1, inputs 10,20,30,40 -> out_data 40,30,20,10. out_last on idx 3.
- Back-pressure: out_ready=0 while three blocks are offered -> in_ready drops after 32 accepts. Outputs stay stable. Releasing out_ready drains both blocks in order with no loss or duplication.
- Ping-pong overlap: stream continuous blocks with alternating scan_rev -> 1 coef/cycle in and out. Each block's direction matches the value sampled at its first write.
- flush after 7 inputs, and rst_n pulsed mid-drain -> next cycle in_ready=1, out_valid=0. The following full block outputs correctly from idx 0.
